// File: rtl/instruction_fetch.sv
// Fetch stage: reads 1-3 instruction bytes at pc_in and hands the assembled instruction to the decoder.
// Optional FETCH_TIMEOUT_EN adds a mem_ack wait limit that raises a sticky fetch_err.
module instruction_fetch #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        flush,
  input  logic [15:0] pc_in,
  output logic        pc_inc,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [7:0]  ir_opcode,
  output logic [15:0] ir_operand,
  output logic [1:0]  ir_len,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic        fetch_err
);

  // state    | meaning
  // S_IDLE   | waiting for run
  // S_REQ    | read outstanding at pc_in
  // S_INC    | pc_inc pulse, byte count advances
  // S_SETTLE | dead cycle while the PC update lands
  // S_HOLD   | instruction offered to the decoder
  // S_FLUSH  | one cycle after a flush before refetching
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_INC, S_SETTLE, S_HOLD, S_FLUSH
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  slot0_q, slot0_d;
  logic [7:0]  slot1_q, slot1_d;
  logic [7:0]  slot2_q, slot2_d;
  logic [1:0]  len_q, len_d;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic        err_q, err_d;
  logic [7:0]  wait_q, wait_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  function automatic logic [1:0] decode_len(input logic [7:0] op);
    case (op[7:6])
      2'b00:   return 2'd1;
      2'b01:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    slot2_d = slot2_q;
    len_d   = len_q;
`ifdef FETCH_TIMEOUT_EN
    err_d   = err_q;
    wait_d  = '0;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef FETCH_TIMEOUT_EN
        if (run && !err_q) state_d = S_REQ;
`else
        if (run) state_d = S_REQ;
`endif
      end
      S_REQ: begin
        if (mem_ack) begin
          case (cnt_q)
            2'd0:    slot0_d = mem_rdata;
            2'd1:    slot1_d = mem_rdata;
            default: slot2_d = mem_rdata;
          endcase
          state_d = S_INC;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wait_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
`endif
      end
      S_INC: begin
        cnt_d   = cnt_q + 2'd1;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == decode_len(slot0_q)) begin
          len_d   = cnt_q;
          state_d = S_HOLD;
        end else begin
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (ir_ready) begin
          cnt_d   = '0;
          state_d = run ? S_REQ : S_IDLE;
        end
      end
      S_FLUSH: state_d = run ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Flush overrides everything above, including a byte captured this cycle.
    if (flush) begin
      state_d = S_FLUSH;
      cnt_d   = '0;
      slot0_d = slot0_q;
      slot1_d = '0;
      slot2_d = '0;
      len_d   = '0;
`ifdef FETCH_TIMEOUT_EN
      err_d   = 1'b0;
      wait_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
      slot2_q <= '0;
      len_q   <= '0;
`ifdef FETCH_TIMEOUT_EN
      err_q   <= 1'b0;
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      slot2_q <= slot2_d;
      len_q   <= len_d;
`ifdef FETCH_TIMEOUT_EN
      err_q   <= err_d;
      wait_q  <= wait_d;
`endif
    end
  end

  assign mem_rd     = (state_q == S_REQ);
  assign mem_addr   = mem_rd ? pc_in : 16'h0000;
  assign pc_inc     = (state_q == S_INC);
  assign ir_valid   = (state_q == S_HOLD);
  assign ir_opcode  = slot0_q;
  assign ir_len     = len_q;
  // Operand bytes beyond the instruction length read as zero.
  assign ir_operand = {(len_q == 2'd3) ? slot2_q : 8'h00,
                       (len_q >= 2'd2) ? slot1_q : 8'h00};
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err  = err_q;
`else
  assign fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: byte-addressed memory model with a PC that follows pc_inc.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n, run, flush, ir_ready;
  logic [15:0] pc_in = 16'h0000;
  logic        pc_inc, mem_rd, mem_ack, ir_valid, fetch_err;
  logic [15:0] mem_addr, ir_operand;
  logic [7:0]  mem_rdata, ir_opcode;
  logic [1:0]  ir_len;

  logic        ack_en;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic [7:0]  mem [0:65535];
  int          inc_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .flush(flush), .pc_in(pc_in),
    .pc_inc(pc_inc), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ir_opcode(ir_opcode),
    .ir_operand(ir_operand), .ir_len(ir_len), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .fetch_err(fetch_err)
  );

  always_comb begin
    mem_ack   = mem_rd && ack_en;
    mem_rdata = mem_rd ? mem[mem_addr] : 8'h00;
  end

  always @(posedge clk) begin
    if (pc_load) pc_in <= pc_load_val;
    else if (pc_inc) pc_in <= pc_in + 16'd1;
    if (pc_inc) inc_cnt <= inc_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pc(input logic [15:0] a);
    pc_load_val = a;
    pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
  endtask

  task automatic drain();
    run = 1'b0;
    ir_ready = 1'b1;
    ack_en = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; flush = 1'b0; ir_ready = 1'b0;
    ack_en = 1'b1; pc_load = 1'b0; pc_load_val = 16'h0000;
    tick();
    tick();
    load_pc(16'h0000);
    checks++;
    if ({pc_inc, mem_rd, ir_valid, fetch_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {pc_inc, mem_rd, ir_valid, fetch_err});
    end
    checks++;
    if (mem_addr !== 16'h0000) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=0000", mem_addr);
    end
    checks++;
    if ({ir_opcode, ir_operand, ir_len} !== 26'd0) begin
      failures++;
      $display("FAIL reset_ir got=%h/%h/%0d exp=00/0000/0", ir_opcode, ir_operand, ir_len);
    end
  endtask

  task automatic test_single_byte();
    int inc0;
    inc0 = inc_cnt;
    ir_ready = 1'b1;
    rst_n = 1'b1;
    run = 1'b1;
    tick();
    checks++;
    if ({mem_rd, mem_ack, mem_addr} !== {1'b1, 1'b1, 16'h0000}) begin
      failures++;
      $display("FAIL single_req got rd=%b ack=%b addr=%h exp 1 1 0000", mem_rd, mem_ack, mem_addr);
    end
    tick();
    run = 1'b0;
    checks++;
    if ({pc_inc, mem_rd} !== 2'b10) begin
      failures++;
      $display("FAIL single_inc got inc=%b rd=%b exp 1 0", pc_inc, mem_rd);
    end
    tick();
    checks++;
    if ({pc_inc, mem_rd, ir_valid} !== 3'b000) begin
      failures++;
      $display("FAIL single_settle got=%b exp=000", {pc_inc, mem_rd, ir_valid});
    end
    tick();
    checks++;
    if ({ir_valid, ir_opcode, ir_operand, ir_len} !== {1'b1, 8'h05, 16'h0000, 2'd1}) begin
      failures++;
      $display("FAIL single_hold got v=%b op=%h opnd=%h len=%0d exp 1 05 0000 1",
               ir_valid, ir_opcode, ir_operand, ir_len);
    end
    checks++;
    if (inc_cnt - inc0 !== 1) begin
      failures++;
      $display("FAIL single_pcinc got=%0d exp=1", inc_cnt - inc0);
    end
    tick();
    checks++;
    if ({ir_valid, mem_rd} !== 2'b00) begin
      failures++;
      $display("FAIL single_idle got v=%b rd=%b exp 0 0", ir_valid, mem_rd);
    end
  endtask

  task automatic test_three_byte();
    int inc0, n, vcyc;
    logic [15:0] addrs [3];
    load_pc(16'h0100);
    inc0 = inc_cnt;
    n = 0;
    vcyc = 0;
    addrs[0] = '0; addrs[1] = '0; addrs[2] = '0;
    ir_ready = 1'b1;
    run = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (mem_rd && mem_ack) begin
        if (n < 3) addrs[n] = mem_addr;
        n++;
      end
      if (ir_valid) begin
        vcyc = c;
        break;
      end
    end
    run = 1'b0;
    checks++;
    if (vcyc !== 10) begin
      failures++;
      $display("FAIL three_latency got=%0d exp=10", vcyc);
    end
    checks++;
    if (n !== 3 || addrs[0] !== 16'h0100 || addrs[1] !== 16'h0101 || addrs[2] !== 16'h0102) begin
      failures++;
      $display("FAIL three_addrs got n=%0d %h %h %h exp 3 0100 0101 0102", n, addrs[0], addrs[1], addrs[2]);
    end
    checks++;
    if ({ir_opcode, ir_operand, ir_len} !== {8'h80, 16'h1234, 2'd3}) begin
      failures++;
      $display("FAIL three_ir got op=%h opnd=%h len=%0d exp 80 1234 3", ir_opcode, ir_operand, ir_len);
    end
    checks++;
    if (inc_cnt - inc0 !== 3) begin
      failures++;
      $display("FAIL three_pcinc got=%0d exp=3", inc_cnt - inc0);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int bad;
    logic seen;
    load_pc(16'h0200);
    ir_ready = 1'b0;
    run = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (ir_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL bp_valid got=0 exp=1 within 30 cycles");
    end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if ({ir_valid, mem_rd, ir_opcode, ir_operand, ir_len} !== {1'b1, 1'b0, 8'h41, 16'h00AA, 2'd2})
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL bp_hold got %0d bad cycles (op=%h opnd=%h len=%0d) exp 0", bad, ir_opcode, ir_operand, ir_len);
    end
    ir_ready = 1'b1;
    tick();
    checks++;
    if ({mem_rd, ir_valid, mem_addr} !== {1'b1, 1'b0, 16'h0202}) begin
      failures++;
      $display("FAIL bp_next got rd=%b v=%b addr=%h exp 1 0 0202", mem_rd, ir_valid, mem_addr);
    end
    drain();
  endtask

  task automatic test_flush();
    int inc0, vseen;
    load_pc(16'h0300);
    inc0 = inc_cnt;
    vseen = 0;
    ir_ready = 1'b1;
    run = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (ir_valid) vseen++;
    end
    checks++;
    if ({mem_rd, mem_ack, mem_addr} !== {1'b1, 1'b1, 16'h0301}) begin
      failures++;
      $display("FAIL flush_setup got rd=%b ack=%b addr=%h exp 1 1 0301", mem_rd, mem_ack, mem_addr);
    end
    flush = 1'b1;
    pc_load_val = 16'h2000;
    pc_load = 1'b1;
    tick();
    flush = 1'b0;
    pc_load = 1'b0;
    if (ir_valid) vseen++;
    checks++;
    if ({pc_inc, mem_rd, ir_valid} !== 3'b000 || inc_cnt - inc0 !== 1) begin
      failures++;
      $display("FAIL flush_dead got inc=%b rd=%b v=%b pcinc=%0d exp 0 0 0 1",
               pc_inc, mem_rd, ir_valid, inc_cnt - inc0);
    end
    tick();
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'h2000}) begin
      failures++;
      $display("FAIL flush_refetch got rd=%b addr=%h exp 1 2000", mem_rd, mem_addr);
    end
    tick();
    tick();
    if (ir_valid) vseen++;
    checks++;
    if (vseen !== 0) begin
      failures++;
      $display("FAIL flush_novalid got=%0d exp=0", vseen);
    end
    tick();
    checks++;
    if ({ir_valid, ir_opcode, ir_operand, ir_len} !== {1'b1, 8'h05, 16'h0000, 2'd1}) begin
      failures++;
      $display("FAIL flush_newir got v=%b op=%h opnd=%h len=%0d exp 1 05 0000 1",
               ir_valid, ir_opcode, ir_operand, ir_len);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    load_pc(16'h0400);
    ack_en = 1'b0;
    run = 1'b1;
    tick();
    tick();
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'h0400}) begin
      failures++;
      $display("FAIL rstmid_req got rd=%b addr=%h exp 1 0400", mem_rd, mem_addr);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({pc_inc, mem_rd, ir_valid, fetch_err, mem_addr, ir_opcode, ir_operand, ir_len} !== 46'd0) begin
      failures++;
      $display("FAIL rstmid_zero got rd=%b addr=%h op=%h opnd=%h len=%0d exp all 0",
               mem_rd, mem_addr, ir_opcode, ir_operand, ir_len);
    end
    rst_n = 1'b1;
    ack_en = 1'b1;
    tick();
    checks++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'h0400}) begin
      failures++;
      $display("FAIL rstmid_restart got rd=%b addr=%h exp 1 0400", mem_rd, mem_addr);
    end
    tick();
    tick();
    tick();
    checks++;
    if ({ir_valid, ir_opcode} !== {1'b1, 8'h05}) begin
      failures++;
      $display("FAIL rstmid_ir got v=%b op=%h exp 1 05", ir_valid, ir_opcode);
    end
    drain();
  endtask

  task automatic test_timeout();
    load_pc(16'h0500);
    ack_en = 1'b0;
    run = 1'b1;
`ifdef FETCH_TIMEOUT_EN
    begin
      int n;
      logic done;
      n = 0;
      done = 1'b0;
      for (int c = 0; c < 40; c++) begin
        tick();
        if (mem_rd) n++;
        if (fetch_err) begin
          done = 1'b1;
          break;
        end
      end
      checks++;
      if (!done || n !== 16 || mem_rd !== 1'b0) begin
        failures++;
        $display("FAIL tmo_err got err=%b reqcycles=%0d rd=%b exp 1 16 0", done, n, mem_rd);
      end
      tick();
      tick();
      checks++;
      if ({mem_rd, fetch_err} !== 2'b01) begin
        failures++;
        $display("FAIL tmo_sticky got rd=%b err=%b exp 0 1", mem_rd, fetch_err);
      end
      ack_en = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (fetch_err !== 1'b0) begin
        failures++;
        $display("FAIL tmo_clear got=%b exp=0", fetch_err);
      end
      tick();
      checks++;
      if ({mem_rd, mem_addr} !== {1'b1, 16'h0500}) begin
        failures++;
        $display("FAIL tmo_refetch got rd=%b addr=%h exp 1 0500", mem_rd, mem_addr);
      end
    end
`else
    begin
      int bad;
      bad = 0;
      tick();
      for (int c = 0; c < 20; c++) begin
        tick();
        if (!mem_rd || fetch_err || mem_addr !== 16'h0500) bad++;
      end
      checks++;
      if (bad !== 0) begin
        failures++;
        $display("FAIL notmo_wait got %0d bad cycles (rd=%b err=%b) exp 0", bad, mem_rd, fetch_err);
      end
    end
`endif
    drain();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h05;
    mem[16'h0100] = 8'h80; mem[16'h0101] = 8'h34; mem[16'h0102] = 8'h12;
    mem[16'h0200] = 8'h41; mem[16'h0201] = 8'hAA; mem[16'h0202] = 8'h00;
    mem[16'h0300] = 8'h80; mem[16'h0301] = 8'h56; mem[16'h0302] = 8'h78;
    mem[16'h2000] = 8'h05;
    mem[16'h0400] = 8'h05;
    mem[16'h0500] = 8'h05;

    test_reset();
    test_single_byte();
    test_three_byte();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_timeout();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage between the 16-bit program counter and the instruction decoder.
- Reads opcode and operand bytes from 8-bit program memory at the current PC, and pulses the PC increment once per byte.
- Assembles a 1–3 byte instruction and hands it to the decoder over a valid/ready handshake.
- A flush input discards partial work when the PC is being reloaded (jump).

Parameters:
- TIMEOUT_CYCLES, 255, mem_ack wait limit before fetch_err. Used only with FETCH_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- run  input  1  fetch enable; sampled only at instruction boundaries
- flush  input  1  abort current fetch (PC reload in progress)
- pc_in  input  16  current PC value from program counter
- pc_inc  output  1  one-cycle increment pulse to program counter
- mem_addr  output  16  program memory address
- mem_rd  output  1  memory read request
- mem_rdata  input  8  memory read data, valid when mem_ack=1
- mem_ack  input  1  read completion strobe
- ir_opcode  output  8  assembled opcode
- ir_operand  output  16  operands: byte2 in [7:0], byte3 in [15:8], unused bits 0
- ir_len  output  2  instruction length in bytes (1..3)
- ir_valid  output  1  instruction available
- ir_ready  input  1  decoder accepts
- fetch_err  output  1  timeout flag, sticky until reset or flush (FETCH_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset (rst_n=0 at posedge clk): state IDLE; all outputs 0; byte count 0. Reset has priority over every other input, including mid-fetch.
- Length decode from opcode[7:6]: 00 gives 1 byte, 01 gives 2 bytes, 10 and 11 give 3 bytes.
- IDLE: if run=1, go to REQ.
- REQ:
  - mem_rd=1 and mem_addr=pc_in; hold both until mem_ack.
  - On mem_ack=1, capture mem_rdata into slot[byte count] and go to INC.
  - mem_rd drops in the cycle after the ack.
- INC: pc_inc=1 for exactly this cycle; byte count increments; go to SETTLE.
- SETTLE:
  - One dead cycle so the PC update is visible; mem_rd=0.
  - If byte count equals the decoded length, go to HOLD; otherwise go to REQ.
- HOLD:
  - ir_valid=1; ir_opcode, ir_operand and ir_len are stable.
  - On ir_valid && ir_ready: clear ir_valid and byte count.
  - Then go to REQ if run=1, else IDLE.
- Minimum latency: 1-byte instruction with ack in the first REQ cycle gives ir_valid in the 4th cycle (REQ, INC, SETTLE, HOLD). Each additional byte adds 3 cycles.
- Flush (flush=1, rst_n=1), from any state:
  - Clears ir_valid, byte count, ir_operand and ir_len; next state is SETTLE-flush (1 cycle); then REQ if run=1, else IDLE.
  - If flush coincides with mem_ack, the byte is discarded and pc_inc is not asserted.
  - If flush coincides with ir_valid && ir_ready, the transfer is still completed on that edge, then the flush applies.
  - A flush asserted during INC still lets that cycle's pc_inc stand (already issued).
- run=0 mid-instruction: the fetch completes and the instruction is held; IDLE is entered only after the handshake.
- pc_in wraps naturally at 0xFFFF to 0x0000. The block does not check for wrap.
- Never more than one outstanding memory read. mem_rd is never high in INC, SETTLE or HOLD.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - An 8-bit wait counter runs in REQ and clears on entry to REQ.
  - If the counter reaches TIMEOUT_CYCLES without mem_ack: set fetch_err=1, drop mem_rd, go to IDLE.
  - fetch_err clears only on reset or flush.
  - While fetch_err=1, IDLE ignores run.
- FETCH_TIMEOUT_EN not defined:
  - No counter; REQ waits indefinitely.
  - fetch_err is constant 0.

Test Plan:
- Reset, pc_in=0x0000, run=1, memory returns 0x05 with immediate ack, ir_ready=1 -> ir_valid in 4th cycle, ir_opcode=0x05, ir_len=1, ir_operand=0x0000, exactly one pc_inc pulse.
- 3-byte fetch: bytes 0x80, 0x34, 0x12 at 0x0100..0x0102, PC model increments on pc_inc -> mem_addr sequence 0x0100, 0x0101, 0x0102; ir_operand=0x1234; ir_len=3; 3 pc_inc pulses.
- Backpressure: ir_ready=0 for 5 cycles on a 2-byte instruction (0x41, 0xAA) -> ir_valid held, outputs stable, mem_rd=0; next fetch starts the cycle after ir_ready=1.
- Flush coincident with mem_ack on the 2nd byte of a 3-byte instruction -> no pc_inc that cycle, ir_valid never asserted; next mem_rd at the reloaded pc_in=0x2000.
- rst_n=0 while in REQ with mem_rd=1 -> next cycle all outputs 0, state IDLE; fetch restarts from pc_in when rst_n=1 and run=1.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=16, mem_ack held 0 -> fetch_err=1 after 16 REQ cycles, mem_rd=0; flush pulse clears fetch_err and refetch begins.
